// File: rtl/projector_setup_sequencer.sv
// ============================================================================
// Module      : projector_setup_sequencer
// Description : Power-up sequencer for the laser projector: power-on delay,
//               galvo homing, calibration rectangle trace, then setup_done.
//               Optional macro SETUP_CALIB_REPEAT_EN adds calib_exit so the
//               rectangle repeats until released.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module projector_setup_sequencer #(
    parameter int unsigned       SETUP_DELAY = 27000000,
    parameter int unsigned       SETTLE      = 2700,
    parameter int unsigned       DWELL       = 270000,
    parameter int                COORD_W     = 12,
    parameter logic [COORD_W-1:0] XMIN       = 12'h200,
    parameter logic [COORD_W-1:0] XMAX       = 12'hE00,
    parameter logic [COORD_W-1:0] YMIN       = 12'h200,
    parameter logic [COORD_W-1:0] YMAX       = 12'hE00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               dac_ready,
`ifdef SETUP_CALIB_REPEAT_EN
    input  logic               calib_exit,
`endif
    output logic [COORD_W-1:0] dac_x,
    output logic [COORD_W-1:0] dac_y,
    output logic               dac_valid,
    output logic               laser_en,
    output logic               setup_start,
    output logic               setup_done,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        ST_POWER_DELAY = 3'd0,
        ST_HOME        = 3'd1,
        ST_HOME_WAIT   = 3'd2,
        ST_CALIB       = 3'd3,
        ST_CALIB_WAIT  = 3'd4,
        ST_READY       = 3'd5
    } state_t;

    // Last count value of each timed state; a zero parameter behaves as one.
    localparam logic [31:0] c_delay_last  = (SETUP_DELAY == 0) ? 32'd0 : 32'(SETUP_DELAY - 1);
    localparam logic [31:0] c_settle_last = (SETTLE == 0)      ? 32'd0 : 32'(SETTLE - 1);
    localparam logic [31:0] c_dwell_last  = (DWELL == 0)       ? 32'd0 : 32'(DWELL - 1);

    localparam logic [COORD_W:0]   c_sum_x  = {1'b0, XMIN} + {1'b0, XMAX};
    localparam logic [COORD_W:0]   c_sum_y  = {1'b0, YMIN} + {1'b0, YMAX};
    localparam logic [COORD_W-1:0] c_home_x = c_sum_x[COORD_W:1];
    localparam logic [COORD_W-1:0] c_home_y = c_sum_y[COORD_W:1];

    function automatic logic [2*COORD_W-1:0] corner_point(input logic [1:0] idx);
        case (idx)
            2'd0:    return {XMIN, YMIN};
            2'd1:    return {XMAX, YMIN};
            2'd2:    return {XMAX, YMAX};
            default: return {XMIN, YMAX};
        endcase
    endfunction

    state_t             r_state;
    logic [31:0]        r_count;
    logic [1:0]         r_idx;
    logic [COORD_W-1:0] r_dac_x;
    logic [COORD_W-1:0] r_dac_y;
    logic               r_dac_valid;
    logic               r_laser_en;
    logic               r_setup_start;
    logic               r_setup_done;

    state_t             w_state_next;
    logic [31:0]        w_count_next;
    logic [1:0]         w_idx_next;
    logic [COORD_W-1:0] w_dac_x_next;
    logic [COORD_W-1:0] w_dac_y_next;
    logic               w_dac_valid_next;
    logic               w_laser_en_next;
    logic               w_setup_start_next;
    logic               w_setup_done_next;

    logic               w_xfer;
    logic               w_calib_exit;
    logic [1:0]         w_idx_inc;

    assign w_xfer    = r_dac_valid & dac_ready;
    assign w_idx_inc = r_idx + 2'd1;

`ifdef SETUP_CALIB_REPEAT_EN
    assign w_calib_exit = calib_exit;
`else
    assign w_calib_exit = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_POWER_DELAY;
            r_count       <= 32'd0;
            r_idx         <= 2'd0;
            r_dac_x       <= '0;
            r_dac_y       <= '0;
            r_dac_valid   <= 1'b0;
            r_laser_en    <= 1'b0;
            r_setup_start <= 1'b0;
            r_setup_done  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_idx         <= w_idx_next;
            r_dac_x       <= w_dac_x_next;
            r_dac_y       <= w_dac_y_next;
            r_dac_valid   <= w_dac_valid_next;
            r_laser_en    <= w_laser_en_next;
            r_setup_start <= w_setup_start_next;
            r_setup_done  <= w_setup_done_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count + 32'd1;
        w_idx_next         = r_idx;
        w_dac_x_next       = r_dac_x;
        w_dac_y_next       = r_dac_y;
        w_dac_valid_next   = r_dac_valid;
        w_laser_en_next    = r_laser_en;
        w_setup_start_next = 1'b0;
        w_setup_done_next  = r_setup_done;

        case (r_state)
            ST_POWER_DELAY: begin
                if (r_count == c_delay_last) begin
                    w_state_next       = ST_HOME;
                    w_count_next       = 32'd0;
                    w_dac_x_next       = c_home_x;
                    w_dac_y_next       = c_home_y;
                    w_dac_valid_next   = 1'b1;
                    w_setup_start_next = 1'b1;
                end
            end
            ST_HOME: begin
                w_count_next = 32'd0;
                if (w_xfer) begin
                    w_state_next     = ST_HOME_WAIT;
                    w_dac_valid_next = 1'b0;
                end
            end
            ST_HOME_WAIT: begin
                if (r_count == c_settle_last) begin
                    w_state_next                 = ST_CALIB;
                    w_count_next                 = 32'd0;
                    w_idx_next                   = 2'd0;
                    {w_dac_x_next, w_dac_y_next} = corner_point(2'd0);
                    w_dac_valid_next             = 1'b1;
                end
            end
            ST_CALIB: begin
                w_count_next = 32'd0;
                if (w_xfer) begin
                    w_state_next     = ST_CALIB_WAIT;
                    w_dac_valid_next = 1'b0;
                    w_laser_en_next  = 1'b1;
                end
            end
            ST_CALIB_WAIT: begin
                if (r_count == c_dwell_last) begin
                    w_count_next = 32'd0;
                    if (r_idx == 2'd3 && w_calib_exit) begin
                        w_state_next      = ST_READY;
                        w_laser_en_next   = 1'b0;
                        w_setup_done_next = 1'b1;
                    end else begin
                        // idx 3 wraps to corner 0 when repeating
                        w_state_next                 = ST_CALIB;
                        w_idx_next                   = w_idx_inc;
                        {w_dac_x_next, w_dac_y_next} = corner_point(w_idx_inc);
                        w_dac_valid_next             = 1'b1;
                    end
                end
            end
            ST_READY: begin
                w_count_next      = 32'd0;
                w_dac_valid_next  = 1'b0;
                w_laser_en_next   = 1'b0;
                w_setup_done_next = 1'b1;
            end
            default: begin
                w_state_next = ST_POWER_DELAY;
                w_count_next = 32'd0;
            end
        endcase

        // Restart abandons any pending point, even one the DAC takes this cycle.
        if (restart) begin
            w_state_next       = ST_POWER_DELAY;
            w_count_next       = 32'd0;
            w_idx_next         = 2'd0;
            w_dac_x_next       = '0;
            w_dac_y_next       = '0;
            w_dac_valid_next   = 1'b0;
            w_laser_en_next    = 1'b0;
            w_setup_start_next = 1'b0;
            w_setup_done_next  = 1'b0;
        end
    end

    assign dac_x       = r_dac_x;
    assign dac_y       = r_dac_y;
    assign dac_valid   = r_dac_valid;
    assign laser_en    = r_laser_en;
    assign setup_start = r_setup_start;
    assign setup_done  = r_setup_done;
    assign state_dbg   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_projector_setup_sequencer.sv
// ============================================================================
// Module      : tb_projector_setup_sequencer
// Description : Directed self-checking bench for projector_setup_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_projector_setup_sequencer;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        dac_ready;
    logic        calib_exit;
    logic [11:0] dac_x;
    logic [11:0] dac_y;
    logic        dac_valid;
    logic        laser_en;
    logic        setup_start;
    logic        setup_done;
    logic [2:0]  state_dbg;

    int n_vec;
    int n_err;

    projector_setup_sequencer #(
        .SETUP_DELAY (10),
        .SETTLE      (4),
        .DWELL       (3),
        .COORD_W     (12),
        .XMIN        (12'h200),
        .XMAX        (12'hE00),
        .YMIN        (12'h200),
        .YMAX        (12'hE00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .dac_ready   (dac_ready),
`ifdef SETUP_CALIB_REPEAT_EN
        .calib_exit  (calib_exit),
`endif
        .dac_x       (dac_x),
        .dac_y       (dac_y),
        .dac_valid   (dac_valid),
        .laser_en    (laser_en),
        .setup_start (setup_start),
        .setup_done  (setup_done),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st,
                             input logic [11:0] x, input logic [11:0] y,
                             input logic v, input logic l,
                             input logic ss, input logic sd);
        check({tag, ".state"},       32'(state_dbg),   32'(st));
        check({tag, ".dac_x"},       32'(dac_x),       32'(x));
        check({tag, ".dac_y"},       32'(dac_y),       32'(y));
        check({tag, ".dac_valid"},   32'(dac_valid),   32'(v));
        check({tag, ".laser_en"},    32'(laser_en),    32'(l));
        check({tag, ".setup_start"}, 32'(setup_start), 32'(ss));
        check({tag, ".setup_done"},  32'(setup_done),  32'(sd));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        restart    = 1'b0;
        dac_ready  = 1'b1;
        calib_exit = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 3'd0, 12'h000, 12'h000, 0, 0, 0, 0);
        reset = 1'b0;

        // Power-on delay: setup_start on the 10th edge after release
        for (int i = 0; i < 9; i++) begin
            tick();
            check("pwr_delay.setup_start", 32'(setup_start), 32'd0);
            check("pwr_delay.state", 32'(state_dbg), 32'd0);
        end
        tick();
        check_all("home", 3'd1, 12'h800, 12'h800, 1, 0, 1, 0);
        tick();
        check_all("home_wait", 3'd2, 12'h800, 12'h800, 0, 0, 0, 0);
        repeat (3) tick();
        check("home_wait_end.state", 32'(state_dbg), 32'd2);
        tick();
        check_all("c0", 3'd3, 12'h200, 12'h200, 1, 0, 0, 0);
        tick();
        check_all("c0_dwell", 3'd4, 12'h200, 12'h200, 0, 1, 0, 0);
        repeat (2) tick();
        check("c0_dwell_end.state", 32'(state_dbg), 32'd4);
        tick();
        check_all("c1", 3'd3, 12'hE00, 12'h200, 1, 1, 0, 0);

        // Backpressure on corner 1
        dac_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("c1_stall", 3'd3, 12'hE00, 12'h200, 1, 1, 0, 0);
        end
        dac_ready = 1'b1;
        tick();
        check_all("c1_dwell", 3'd4, 12'hE00, 12'h200, 0, 1, 0, 0);
        repeat (2) tick();
        check("c1_dwell_end.state", 32'(state_dbg), 32'd4);
        tick();
        check_all("c2", 3'd3, 12'hE00, 12'hE00, 1, 1, 0, 0);
        tick();
        check_all("c2_dwell", 3'd4, 12'hE00, 12'hE00, 0, 1, 0, 0);
        repeat (2) tick();
        tick();
        check_all("c3", 3'd3, 12'h200, 12'hE00, 1, 1, 0, 0);
        tick();
        check_all("c3_dwell", 3'd4, 12'h200, 12'hE00, 0, 1, 0, 0);
        repeat (2) tick();
        check("c3_dwell_end.state", 32'(state_dbg), 32'd4);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ready.state",      32'(state_dbg),  32'd5);
            check("ready.setup_done", 32'(setup_done), 32'd1);
            check("ready.laser_en",   32'(laser_en),   32'd0);
            check("ready.dac_valid",  32'(dac_valid),  32'd0);
            tick();
        end

        // Restart from READY
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart1.state",      32'(state_dbg),  32'd0);
        check("restart1.setup_done", 32'(setup_done), 32'd0);
        repeat (9) tick();
        check("restart1_delay.setup_start", 32'(setup_start), 32'd0);
        tick();
        check_all("restart1_home", 3'd1, 12'h800, 12'h800, 1, 0, 1, 0);

        // Run to corner 2 and restart while its point is pending
        tick();
        repeat (4) tick();
        check("run2_c0.state", 32'(state_dbg), 32'd3);
        repeat (4) tick();
        check("run2_c1.dac_x", 32'(dac_x), 32'hE00);
        repeat (4) tick();
        check_all("run2_c2", 3'd3, 12'hE00, 12'hE00, 1, 1, 0, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart2.state",     32'(state_dbg), 32'd0);
        check("restart2.dac_valid", 32'(dac_valid), 32'd0);
        check("restart2.laser_en",  32'(laser_en),  32'd0);
        repeat (9) tick();
        check("restart2_delay.state", 32'(state_dbg), 32'd0);
        tick();
        check_all("restart2_home", 3'd1, 12'h800, 12'h800, 1, 0, 1, 0);

        // Async reset between edges in HOME_WAIT
        repeat (2) tick();
        check("pre_rst.state", 32'(state_dbg), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 3'd0, 12'h000, 12'h000, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

`ifdef SETUP_CALIB_REPEAT_EN
        // calib_exit low: corner 3 wraps back to corner 0
        calib_exit = 1'b0;
        repeat (10) tick();
        check("rep_home.state", 32'(state_dbg), 32'd1);
        repeat (17) tick();
        check_all("rep_c3", 3'd3, 12'h200, 12'hE00, 1, 1, 0, 0);
        repeat (4) tick();
        check_all("rep_c0", 3'd3, 12'h200, 12'h200, 1, 1, 0, 0);
        repeat (12) tick();
        check("rep_c3b.state", 32'(state_dbg), 32'd3);
        repeat (3) tick();
        check("rep_final_dwell.state", 32'(state_dbg), 32'd4);
        calib_exit = 1'b1;
        tick();
        check("rep_exit.state",      32'(state_dbg),  32'd5);
        check("rep_exit.setup_done", 32'(setup_done), 32'd1);
        check("rep_exit.laser_en",   32'(laser_en),   32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
